// File: rtl/ifetch_pair.sv
// Fetch-side producer for the instruction buffer: fetch PC generation, cache req/addr_ok/data_ok
// handshake, and 64-bit response split into up to two slots. Macro IFETCH_BPU_EN enables prediction.
module ifetch_pair #(
    parameter logic [31:0] RESET_PC       = 32'hBFC0_0000,
    parameter int          BPBPacketWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    input  logic                      instbuffer_full,
    output logic                      inst_req,
    output logic [31:0]               inst_addr,
    input  logic                      inst_addr_ok,
    input  logic                      inst_data_ok,
    input  logic [63:0]               inst_rdata,
    input  logic                      bpu_taken,
    input  logic                      bpu_slot,
    input  logic [31:0]               bpu_target,
    input  logic [BPBPacketWidth-1:0] bpu_pkt,
    output logic [31:0]               inst_o1,
    output logic [31:0]               inst_o2,
    output logic [31:0]               inst_addr_o1,
    output logic [31:0]               inst_addr_o2,
    output logic                      inst_valid_o1,
    output logic                      inst_valid_o2,
    output logic [BPBPacketWidth-1:0] predict_pkt_o1,
    output logic [BPBPacketWidth-1:0] predict_pkt_o2
);

`ifdef IFETCH_BPU_EN
    localparam bit BpuEn = 1'b1;
`else
    localparam bit BpuEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;            // next address to fetch
    logic [31:0] pending_tgt;   // branch target held across the delay-slot fetch
    logic        force_single;
    logic        drop;
    logic [31:0] req_addr;      // address of the request in flight, held for the handshake
    logic        req_single;    // in-flight request writes slot 1 only

    logic [31:0] pc_n;
    logic [31:0] tgt_n;
    logic        fs_n;
    logic        drop_n;
    logic        resp;
    logic        accept;
    logic        pair;
    logic        start_req;
    logic [31:0] seq_pc;
    logic [BPBPacketWidth-1:0] pkt1_n;
    logic [BPBPacketWidth-1:0] pkt2_n;

    assign inst_req  = (state == S_REQ);
    assign inst_addr = req_addr;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        pc_n   = pc;
        tgt_n  = pending_tgt;
        fs_n   = force_single;
        drop_n = drop;
        pkt1_n = '0;
        pkt2_n = '0;
        resp   = (state == S_WAIT) && inst_data_ok;
        accept = resp && !drop && !flush;
        pair   = !req_single;
        seq_pc = req_addr + (pair ? 32'd8 : 32'd4);

        if (resp && drop) begin
            drop_n = 1'b0;
        end

        if (accept) begin
            if (force_single) begin
                // This response is the delay slot; now jump to the remembered target.
                pc_n = pending_tgt;
                fs_n = 1'b0;
            end else begin
                pc_n = seq_pc;
                if (BpuEn) begin
                    if (pair && bpu_slot) begin
                        pkt2_n = bpu_pkt;
                    end else begin
                        pkt1_n = bpu_pkt;
                    end
                    if (bpu_taken) begin
                        if (pair && !bpu_slot) begin
                            pc_n = bpu_target;
                        end else begin
                            // Delay slot not in this pair: fetch it alone first.
                            fs_n  = 1'b1;
                            tgt_n = bpu_target;
                        end
                    end
                end
            end
        end

        if (flush) begin
            pc_n = flush_pc;
            fs_n = 1'b0;
            if ((state == S_REQ) || ((state == S_WAIT) && !inst_data_ok)) begin
                drop_n = 1'b1;
            end
        end

        start_req = ((state == S_IDLE) || resp) && !instbuffer_full;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            pending_tgt    <= '0;
            force_single   <= 1'b0;
            drop           <= 1'b0;
            req_addr       <= RESET_PC;
            req_single     <= 1'b0;
            inst_o1        <= '0;
            inst_o2        <= '0;
            inst_addr_o1   <= '0;
            inst_addr_o2   <= '0;
            inst_valid_o1  <= 1'b0;
            inst_valid_o2  <= 1'b0;
            predict_pkt_o1 <= '0;
            predict_pkt_o2 <= '0;
        end else begin
            pc           <= pc_n;
            pending_tgt  <= tgt_n;
            force_single <= fs_n;
            drop         <= drop_n;

            case (state)
                S_IDLE: if (!instbuffer_full) state <= S_REQ;
                S_REQ:  if (inst_addr_ok) state <= S_WAIT;
                S_WAIT: if (inst_data_ok) state <= instbuffer_full ? S_IDLE : S_REQ;
                default: state <= S_IDLE;
            endcase

            if (start_req) begin
                req_addr   <= pc_n;
                req_single <= pc_n[2] | fs_n;
            end

            inst_valid_o1 <= accept;
            inst_valid_o2 <= accept && pair;
            if (accept) begin
                inst_o1        <= req_addr[2] ? inst_rdata[63:32] : inst_rdata[31:0];
                inst_o2        <= pair ? inst_rdata[63:32] : 32'd0;
                inst_addr_o1   <= req_addr;
                inst_addr_o2   <= req_addr + 32'd4;
                predict_pkt_o1 <= pkt1_n;
                predict_pkt_o2 <= pkt2_n;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_pair.sv
// Self-checking bench for ifetch_pair: directed test-plan steps followed by randomized cache
// latency, flush, buffer-full and prediction traffic checked against a transaction-level model.
module tb_ifetch_pair;
    localparam int          PW  = 16;
    localparam logic [31:0] RPC = 32'hBFC0_0000;
`ifdef IFETCH_BPU_EN
    localparam bit BPU_EN = 1'b1;
`else
    localparam bit BPU_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [31:0]   flush_pc = '0;
    logic          instbuffer_full = 1'b0;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_addr_ok = 1'b0;
    logic          inst_data_ok = 1'b0;
    logic [63:0]   inst_rdata = '0;
    logic          bpu_taken = 1'b0;
    logic          bpu_slot = 1'b0;
    logic [31:0]   bpu_target = '0;
    logic [PW-1:0] bpu_pkt = '0;
    logic [31:0]   inst_o1, inst_o2, inst_addr_o1, inst_addr_o2;
    logic          inst_valid_o1, inst_valid_o2;
    logic [PW-1:0] predict_pkt_o1, predict_pkt_o2;

    always #5 clk = ~clk;

    ifetch_pair #(.RESET_PC(RPC), .BPBPacketWidth(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .instbuffer_full(instbuffer_full), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .bpu_taken(bpu_taken), .bpu_slot(bpu_slot), .bpu_target(bpu_target), .bpu_pkt(bpu_pkt),
        .inst_o1(inst_o1), .inst_o2(inst_o2), .inst_addr_o1(inst_addr_o1),
        .inst_addr_o2(inst_addr_o2), .inst_valid_o1(inst_valid_o1), .inst_valid_o2(inst_valid_o2),
        .predict_pkt_o1(predict_pkt_o1), .predict_pkt_o2(predict_pkt_o2)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model: next fetch address, delay-slot bookkeeping, and the cache-side view
    // of the request in flight (0 none, 1 address phase, 2 data phase).
    logic [31:0] m_pc = RPC;
    logic [31:0] m_tgt = '0;
    bit          m_fs = 1'b0;
    bit          m_drop = 1'b0;
    int          t_phase = 0;
    logic [31:0] c_addr = RPC;
    bit          c_single = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit full, input bit fl, input logic [31:0] fpc, input bit aok,
                        input bit dok, input bit tk, input bit sl, input logic [31:0] tg,
                        input logic [PW-1:0] pk);
        int            p;
        bit            pair;
        bit            ev1, ev2;
        logic [31:0]   base, eo1, eo2, ea1, ea2;
        logic [PW-1:0] ep1, ep2;
        base = {c_addr[31:3], 3'b000};
        instbuffer_full = full;
        flush           = fl;
        flush_pc        = fpc;
        inst_addr_ok    = aok;
        inst_data_ok    = dok;
        inst_rdata      = dok ? {word_at(base + 32'd4), word_at(base)} : {$urandom, $urandom};
        bpu_taken       = tk;
        bpu_slot        = sl;
        bpu_target      = tg;
        bpu_pkt         = pk;
        @(posedge clk);
        #1;
        p   = t_phase;
        ev1 = 1'b0;
        ev2 = 1'b0;
        eo1 = '0; eo2 = '0; ea1 = '0; ea2 = '0; ep1 = '0; ep2 = '0;
        if (p == 2 && dok) begin
            if (fl || m_drop) begin
                m_drop = 1'b0;
            end else begin
                pair = !c_single;
                ev1  = 1'b1;
                ev2  = pair;
                eo1  = word_at(c_addr);
                eo2  = word_at(c_addr + 32'd4);
                ea1  = c_addr;
                ea2  = c_addr + 32'd4;
                if (m_fs) begin
                    m_pc = m_tgt;
                    m_fs = 1'b0;
                end else begin
                    m_pc = c_addr + (pair ? 32'd8 : 32'd4);
                    if (BPU_EN) begin
                        if (pair && sl) ep2 = pk;
                        else            ep1 = pk;
                        if (tk) begin
                            if (pair && !sl) m_pc = tg;
                            else begin
                                m_fs  = 1'b1;
                                m_tgt = tg;
                            end
                        end
                    end
                end
            end
        end
        if (fl) begin
            m_pc = fpc;
            m_fs = 1'b0;
            if (p == 1 || (p == 2 && !dok)) m_drop = 1'b1;
        end
        case (p)
            0:       if (!full) t_phase = 1;
            1:       if (aok) t_phase = 2;
            default: if (dok) t_phase = full ? 0 : 1;
        endcase
        if (t_phase == 1 && p != 1) begin
            c_addr   = m_pc;
            c_single = m_pc[2] | m_fs;
        end
        chk("inst_req", 64'(inst_req), 64'(t_phase == 1));
        if (t_phase == 1) chk("inst_addr", 64'(inst_addr), 64'(c_addr));
        chk("valid1", 64'(inst_valid_o1), 64'(ev1));
        chk("valid2", 64'(inst_valid_o2), 64'(ev2));
        if (ev1) begin
            chk("inst_o1", 64'(inst_o1), 64'(eo1));
            chk("addr_o1", 64'(inst_addr_o1), 64'(ea1));
            chk("addr_o2", 64'(inst_addr_o2), 64'(ea2));
            chk("pkt_o1", 64'(predict_pkt_o1), 64'(ep1));
            chk("pkt_o2", 64'(predict_pkt_o2), 64'(ep2));
        end
        if (ev2) chk("inst_o2", 64'(inst_o2), 64'(eo2));
    endtask

    // Zero-wait cache: accept and answer as soon as the phase allows.
    task automatic step_auto(input bit full, input bit fl, input logic [31:0] fpc, input bit tk,
                             input bit sl, input logic [31:0] tg, input logic [PW-1:0] pk);
        step(full, fl, fpc, t_phase == 1, t_phase == 2, tk, sl, tg, pk);
    endtask

    initial begin
        logic [31:0] r;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(inst_req), 64'(0));
        chk("rst_addr", 64'(inst_addr), 64'(RPC));
        chk("rst_v1", 64'(inst_valid_o1), 64'(0));
        chk("rst_v2", 64'(inst_valid_o2), 64'(0));
        chk("rst_o1", 64'(inst_o1), 64'(0));
        chk("rst_pkt1", 64'(predict_pkt_o1), 64'(0));
        rst = 1'b1;

        // Sequential pairs from reset with a zero-wait cache.
        step_auto(0, 0, 0, 0, 0, 0, 0);
        chk("first_req", 64'(inst_req), 64'(1));
        chk("first_addr", 64'(inst_addr), 64'h0BFC0_0000);
        for (int k = 0; k < 3; k++) begin
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            chk("seq_addr_o1", 64'(inst_addr_o1), 64'(RPC + 32'(8 * k)));
            chk("seq_valid2", 64'(inst_valid_o2), 64'(1));
            chk("seq_next_req", 64'(inst_addr), 64'(RPC + 32'(8 * (k + 1))));
        end

        // Flush during REQ to an odd word: dropped response, single, then pairs.
        step_auto(0, 1, 32'hBFC0_0104, 0, 0, 0, 0);
        step_auto(0, 0, 0, 0, 0, 0, 0);
        chk("flush_drop_v1", 64'(inst_valid_o1), 64'(0));
        chk("flush_req", 64'(inst_addr), 64'h0BFC0_0104);
        step_auto(0, 0, 0, 0, 0, 0, 0);
        step_auto(0, 0, 0, 0, 0, 0, 0);
        chk("single_v1", 64'(inst_valid_o1), 64'(1));
        chk("single_v2", 64'(inst_valid_o2), 64'(0));
        chk("single_addr", 64'(inst_addr_o1), 64'h0BFC0_0104);
        chk("after_single", 64'(inst_addr), 64'h0BFC0_0108);
        step_auto(0, 0, 0, 0, 0, 0, 0);
        step_auto(0, 0, 0, 0, 0, 0, 0);
        chk("pair108_v2", 64'(inst_valid_o2), 64'(1));
        chk("pair108_addr", 64'(inst_addr_o1), 64'h0BFC0_0108);

        // Flush in WAIT before data_ok.
        step_auto(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("wait_flush_v1", 64'(inst_valid_o1), 64'(0));
        chk("wait_flush_req", 64'(inst_addr), 64'h0_8000_0000);

        // Buffer full during WAIT: response still written, no new request until it drops.
        step_auto(0, 0, 0, 0, 0, 0, 0);
        step_auto(1, 0, 0, 0, 0, 0, 0);
        chk("full_written", 64'(inst_valid_o1), 64'(1));
        chk("full_no_req", 64'(inst_req), 64'(0));
        step_auto(1, 0, 0, 0, 0, 0, 0);
        step_auto(1, 0, 0, 0, 0, 0, 0);
        chk("full_held", 64'(inst_req), 64'(0));
        step_auto(0, 0, 0, 0, 0, 0, 0);
        chk("full_resume", 64'(inst_req), 64'(1));
        chk("full_resume_addr", 64'(inst_addr), 64'h0_8000_0008);

        if (BPU_EN) begin
            step_auto(0, 1, 32'h0040_0000, 0, 0, 0, 0);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 1, 1, 32'h0040_0100, 16'hA5C3);
            chk("slot2_pkt2", 64'(predict_pkt_o2), 64'hA5C3);
            chk("slot2_pkt1", 64'(predict_pkt_o1), 64'(0));
            chk("slot2_delay_req", 64'(inst_addr), 64'h0040_0008);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            chk("delay_v2", 64'(inst_valid_o2), 64'(0));
            chk("delay_addr", 64'(inst_addr_o1), 64'h0040_0008);
            chk("delay_then_tgt", 64'(inst_addr), 64'h0040_0100);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 1, 0, 32'h0040_0200, 16'h3C5A);
            chk("slot1_pkt1", 64'(predict_pkt_o1), 64'h3C5A);
            chk("slot1_tgt", 64'(inst_addr), 64'h0040_0200);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            step_auto(0, 0, 0, 0, 0, 0, 0);
            chk("slot1_no_refetch", 64'(inst_addr_o1), 64'h0040_0200);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            step(($urandom % 4) == 0, ($urandom % 20) == 0, {r[31:2], 2'b00},
                 (t_phase == 1) && ($urandom % 2 == 0), (t_phase == 2) && ($urandom % 3 != 0),
                 $urandom % 2 == 0, $urandom % 2 == 0, {$urandom, 2'b00} >> 2 << 2,
                 PW'($urandom));
        end

        // Reset mid-transaction abandons everything at once.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_req", 64'(inst_req), 64'(0));
        chk("midrst_addr", 64'(inst_addr), 64'(RPC));
        chk("midrst_v1", 64'(inst_valid_o1), 64'(0));
        chk("midrst_o1", 64'(inst_o1), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_pair.md
# ifetch_pair

Fetch-side producer that feeds the instruction buffer. Generates the fetch PC, drives a req/addr_ok/data_ok handshake to the instruction cache, and splits each 64-bit response into up to two instruction slots. Writes those slots, with addresses and branch-predictor packets, into the buffer's write port. Stalls on buffer-full and handles pipeline flushes, including responses already in flight.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `flush` input 1: redirect request.
- `flush_pc` input 32: redirect target, sampled when `flush`=1.
- `instbuffer_full` input 1: buffer almost-full; no new request may start while it is high.
- `inst_req` output 1: cache request.
- `inst_addr` output 32: request address, 8-byte-aligned pair base or word address.
- `inst_addr_ok` input 1: request accepted.
- `inst_data_ok` input 1: response valid.
- `inst_rdata` input 64: response data; [31:0] is the word at `addr&~7`, [63:32] is the word at `+4`.
- `bpu_taken` input 1, `bpu_slot` input 1, `bpu_target` input 32, `bpu_pkt` input `BPBPacketWidth`: prediction for the pair, valid with `inst_data_ok`.
- `inst_o1`, `inst_o2` output 32 each: instruction slots.
- `inst_addr_o1`, `inst_addr_o2` output 32 each: slot addresses.
- `inst_valid_o1`, `inst_valid_o2` output 1 each: slot write enables.
- `predict_pkt_o1`, `predict_pkt_o2` output `BPBPacketWidth` each: prediction packets per slot.

## Operation
- State machine:
  - IDLE: no request outstanding.
  - REQ: `inst_req`=1, `inst_addr`=pc; both held stable until `inst_addr_ok`.
  - WAIT: waiting for `inst_data_ok`. At most one request is outstanding.
- Transitions:
  - IDLE→REQ when `!instbuffer_full`.
  - REQ→WAIT on `inst_addr_ok`.
  - WAIT→REQ on `inst_data_ok` if `!instbuffer_full`, otherwise WAIT→IDLE.
- Pair width:
  - If pc[2]=0 and `force_single`=0: two slots; sequential next pc = pc+8.
  - Otherwise: one slot (slot 1 only, data taken from the pc[2] half); next pc = pc+4.
- Output fields: `inst_addr_o1`=pc and `inst_addr_o2`=pc+4, both with 32-bit wrap.
- Prediction, applied on response:
  - Taken on the slot-2 branch (`bpu_slot`=1), or on a slot-1 branch that has no slot 2: the delay slot has not been fetched yet.
    - Set `force_single`=1 and `pending_tgt`=`bpu_target`.
    - Fetch exactly one word at the sequential pc.
    - Then set pc=`pending_tgt` and clear `force_single`.
  - Taken on slot 1 with slot 2 present (the delay slot is in the pair): next pc = `bpu_target`.
  - The packet goes only to the branch slot's `predict_pkt_o*`. The other slot gets 0.
- Flush:
  - pc←`flush_pc`; clear `force_single`.
  - If a request is in REQ or WAIT, set `drop`=1. In REQ the request still completes its handshake. The matching response is discarded: no valid outputs, no pc or prediction update. After that response, `drop` clears.
  - A flush in the same cycle as `inst_data_ok` discards that response.
  - A flush in IDLE takes effect on the next request.
  - A later flush while `drop`=1 only updates pc.
- `instbuffer_full` blocks only the start of a new request. A request already in flight always completes and is written.

## Timing
- Reset values:
  - state IDLE; pc=`RESET_PC`.
  - `inst_req`=0, `inst_addr`=`RESET_PC`.
  - All `inst_valid_o*`=0; all data, address and packet outputs 0.
  - `drop`=0, `force_single`=0.
- Asserting reset mid-transaction abandons it immediately. The cache side is reset by the same signal.
- `inst_req` is combinational from state (REQ).
- Slot outputs are registered: `inst_data_ok` in cycle N gives `inst_valid_o*` in cycle N+1 for exactly one cycle.
- Minimum request spacing: data_ok in cycle N, next `inst_req` in cycle N+1. Throughput is 1 pair per 2 cycles with a zero-wait cache.
- The first `inst_req` after reset release comes in the first clock edge +1 cycle.

## Configuration
- `IFETCH_BPU_EN`
  - Defined: prediction redirect, delay-slot `force_single` handling and packet forwarding as above.
  - Undefined: `bpu_*` inputs ignored; fetch is strictly sequential except for flush; `predict_pkt_o*`=0.

## Test plan
- Reset then zero-wait cache, buffer never full: requests at BFC00000, BFC00008, BFC00010; each pair appears one cycle after data_ok with `inst_valid_o1`=`inst_valid_o2`=1.
- `flush_pc`=BFC00104: single-slot fetch at BFC00104 (valid2=0), then pairs at BFC00108 onward.
- Flush to 80000000 in WAIT, before data_ok: the pending response produces no valid outputs; the next request is 80000000.
- `instbuffer_full`=1 during WAIT: the response is still written; `inst_req` stays 0 until full drops, then resumes at the next pc.
- (`IFETCH_BPU_EN`) Pair at 00400000, taken on slot 2 with target 00400100: single fetch at 00400008 with valid2=0, then a pair at 00400100. `predict_pkt_o2` carries `bpu_pkt` and `predict_pkt_o1`=0.
- (`IFETCH_BPU_EN`) Taken on slot 1 with target 00400200: next request 00400200, with no delay-slot refetch.
